// File: rtl/regwrite_arbiter.sv
// rtl/regwrite_arbiter.sv - two-source register-bank writeback arbiter with 2-deep queues
//
// Merges ALU and load (Mem) writeback requests into one registered
// register-bank write port. Each source has a 2-entry FIFO of {AW, Data};
// heads are arbitrated round-robin on a tie (ALU wins the first tie after
// reset). Writes to register 0 are consumed but leave RegWrite low.
//
// Build option: define REGWRITE_MEM_PRIORITY_EN to give a non-empty Mem
// FIFO fixed priority over ALU instead of round-robin.
//
// Ports:
//   clk, rst_n                   rising-edge clock, async active-low reset
//   AluValid/AluAW/AluData       ALU writeback request
//   AluReady                     ALU FIFO not full
//   MemValid/MemAW/MemData       load writeback request
//   MemReady                     Mem FIFO not full
//   RegWrite/AW/WriteData        registered register-bank write port
//   Busy                         any entry queued or a write in flight

module regwrite_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              AluValid,
  input  logic [ADDR_W-1:0] AluAW,
  input  logic [DATA_W-1:0] AluData,
  output logic              AluReady,
  input  logic              MemValid,
  input  logic [ADDR_W-1:0] MemAW,
  input  logic [DATA_W-1:0] MemData,
  output logic              MemReady,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] AW,
  output logic [DATA_W-1:0] WriteData,
  output logic              Busy
);

  localparam int EW = ADDR_W + DATA_W;

  // FIFO storage and bookkeeping, one set per source
  logic [EW-1:0] alu_fifo_q [2];
  logic [EW-1:0] mem_fifo_q [2];
  logic          alu_wp_q, alu_rp_q;
  logic          mem_wp_q, mem_rp_q;
  logic [1:0]    alu_cnt_q, alu_cnt_d;
  logic [1:0]    mem_cnt_q, mem_cnt_d;

`ifndef REGWRITE_MEM_PRIORITY_EN
  // 1 when ALU was granted most recently, 0 when Mem was
  logic          last_alu_q;
`endif

  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] aw_q, aw_d;
  logic [DATA_W-1:0] wd_q, wd_d;

  logic          alu_push, mem_push;
  logic          alu_ne, mem_ne;
  logic          grant_alu, grant_mem;
  logic [EW-1:0] alu_head, mem_head, sel_head;

  // Ready depends only on registered counts: a full FIFO refuses a push
  // even if its head is being popped at the same edge.
  assign AluReady = (alu_cnt_q != 2'd2);
  assign MemReady = (mem_cnt_q != 2'd2);
  assign alu_push = AluValid & AluReady;
  assign mem_push = MemValid & MemReady;
  assign alu_ne   = (alu_cnt_q != 2'd0);
  assign mem_ne   = (mem_cnt_q != 2'd0);
  assign alu_head = alu_fifo_q[alu_rp_q];
  assign mem_head = mem_fifo_q[mem_rp_q];

  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
`ifdef REGWRITE_MEM_PRIORITY_EN
    if (mem_ne)      grant_mem = 1'b1;
    else if (alu_ne) grant_alu = 1'b1;
`else
    if (alu_ne && mem_ne) begin
      if (last_alu_q) grant_mem = 1'b1;
      else            grant_alu = 1'b1;
    end else if (alu_ne) begin
      grant_alu = 1'b1;
    end else if (mem_ne) begin
      grant_mem = 1'b1;
    end
`endif
  end

  assign sel_head = grant_alu ? alu_head : mem_head;

  always_comb begin
    alu_cnt_d   = alu_cnt_q + {1'b0, alu_push} - {1'b0, grant_alu};
    mem_cnt_d   = mem_cnt_q + {1'b0, mem_push} - {1'b0, grant_mem};
    reg_write_d = 1'b0;
    aw_d        = aw_q;
    wd_d        = wd_q;
    if (grant_alu || grant_mem) begin
      aw_d        = sel_head[EW-1:DATA_W];
      wd_d        = sel_head[DATA_W-1:0];
      // register 0 is popped like any other write but never written
      reg_write_d = (sel_head[EW-1:DATA_W] != '0);
    end
  end

  // Entry storage needs no reset: counts gate every read of it.
  always_ff @(posedge clk) begin
    if (alu_push) alu_fifo_q[alu_wp_q] <= {AluAW, AluData};
    if (mem_push) mem_fifo_q[mem_wp_q] <= {MemAW, MemData};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_cnt_q   <= 2'd0;
      mem_cnt_q   <= 2'd0;
      alu_wp_q    <= 1'b0;
      alu_rp_q    <= 1'b0;
      mem_wp_q    <= 1'b0;
      mem_rp_q    <= 1'b0;
`ifndef REGWRITE_MEM_PRIORITY_EN
      last_alu_q  <= 1'b0;
`endif
      reg_write_q <= 1'b0;
      aw_q        <= '0;
      wd_q        <= '0;
    end else begin
      alu_cnt_q   <= alu_cnt_d;
      mem_cnt_q   <= mem_cnt_d;
      if (alu_push)  alu_wp_q <= ~alu_wp_q;
      if (grant_alu) alu_rp_q <= ~alu_rp_q;
      if (mem_push)  mem_wp_q <= ~mem_wp_q;
      if (grant_mem) mem_rp_q <= ~mem_rp_q;
`ifndef REGWRITE_MEM_PRIORITY_EN
      if (grant_alu || grant_mem) last_alu_q <= grant_alu;
`endif
      reg_write_q <= reg_write_d;
      aw_q        <= aw_d;
      wd_q        <= wd_d;
    end
  end

  assign RegWrite  = reg_write_q;
  assign AW        = aw_q;
  assign WriteData = wd_q;
  assign Busy      = alu_ne | mem_ne | reg_write_q;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// tb/tb_regwrite_arbiter.sv - self-checking bench for regwrite_arbiter

module tb_regwrite_arbiter;

  logic        clk, rst_n;
  logic        AluValid, MemValid, AluReady, MemReady, RegWrite, Busy;
  logic [4:0]  AluAW, MemAW, AW;
  logic [31:0] AluData, MemData, WriteData;

  int total = 0;
  int bad   = 0;

  regwrite_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .AluValid(AluValid), .AluAW(AluAW), .AluData(AluData), .AluReady(AluReady),
    .MemValid(MemValid), .MemAW(MemAW), .MemData(MemData), .MemReady(MemReady),
    .RegWrite(RegWrite), .AW(AW), .WriteData(WriteData), .Busy(Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-source queues of accepted writes plus who won last
  logic [36:0] m_alu[$];
  logic [36:0] m_mem[$];
  bit          m_last_alu;
  bit          m_rw;
  logic [4:0]  m_aw;
  logic [31:0] m_wd;
  bit          obs_alu_acc;

  task automatic model_reset();
    m_alu.delete();
    m_mem.delete();
    m_last_alu = 1'b0;
    m_rw = 1'b0;
    m_aw = '0;
    m_wd = '0;
  endtask

  task automatic model_edge(input bit av, input logic [4:0] aaw, input logic [31:0] ad,
                            input bit mv, input logic [4:0] maw, input logic [31:0] md);
    bit a_rdy, b_rdy;
    int g;
    logic [36:0] e;
    a_rdy = (m_alu.size() != 2);
    b_rdy = (m_mem.size() != 2);
    g = 0;
    if (m_alu.size() > 0 && m_mem.size() > 0) begin
`ifdef REGWRITE_MEM_PRIORITY_EN
      g = 2;
`else
      g = m_last_alu ? 2 : 1;
`endif
    end else if (m_alu.size() > 0) g = 1;
    else if (m_mem.size() > 0) g = 2;
    e = '0;
    if (g == 1) begin e = m_alu.pop_front(); m_last_alu = 1'b1; end
    if (g == 2) begin e = m_mem.pop_front(); m_last_alu = 1'b0; end
    if (g != 0) begin
      m_aw = e[36:32];
      m_wd = e[31:0];
      m_rw = (m_aw != 0);
    end else begin
      m_rw = 1'b0;
    end
    if (av && a_rdy) m_alu.push_back({aaw, ad});
    if (mv && b_rdy) m_mem.push_back({maw, md});
  endtask

  function automatic logic [40:0] model_vec();
    bit busy;
    busy = (m_alu.size() != 0) || (m_mem.size() != 0) || m_rw;
    return {m_rw, m_aw, m_wd, m_alu.size() != 2, m_mem.size() != 2, busy};
  endfunction

  function automatic logic [40:0] dut_vec();
    return {RegWrite, AW, WriteData, AluReady, MemReady, Busy};
  endfunction

  task automatic step(input bit av, input logic [4:0] aaw, input logic [31:0] ad,
                      input bit mv, input logic [4:0] maw, input logic [31:0] md);
    AluValid = av; AluAW = aaw; AluData = ad;
    MemValid = mv; MemAW = maw; MemData = md;
    obs_alu_acc = av && AluReady;
    @(posedge clk);
    model_edge(av, aaw, ad, mv, maw, md);
    #1;
  endtask

  task automatic idle();
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  task automatic do_reset();
    AluValid = 0; MemValid = 0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    AluValid = 0; AluAW = 0; AluData = 0;
    MemValid = 0; MemAW = 0; MemData = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({RegWrite, AW, WriteData, Busy} !== 39'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", {RegWrite, AW, WriteData, Busy});
    end
    rst_n = 1'b1;
    model_reset();
    idle();
    total++;
    if ({AluReady, MemReady, Busy, RegWrite} !== 4'b1100) begin
      bad++;
      $display("FAIL reset_release: rdyA/rdyM/busy/rw got %b want 1100",
               {AluReady, MemReady, Busy, RegWrite});
    end
  endtask

  task automatic test_single_write();
    do_reset();
    step(1, 5'd5, 32'h1234, 0, 5'd0, 32'd0);
    total++;
    if (RegWrite !== 1'b0 || Busy !== 1'b1) begin
      bad++;
      $display("FAIL single_e1: rw=%b busy=%b want rw=0 busy=1", RegWrite, Busy);
    end
    idle();
    total++;
    if (RegWrite !== 1'b1 || AW !== 5'd5 || WriteData !== 32'h1234) begin
      bad++;
      $display("FAIL single_e2: rw=%b aw=%0d wd=%h want 1 5 1234", RegWrite, AW, WriteData);
    end
    idle();
    total++;
    if (RegWrite !== 1'b0 || Busy !== 1'b0) begin
      bad++;
      $display("FAIL single_e3: rw=%b busy=%b want 0 0", RegWrite, Busy);
    end
  endtask

  task automatic test_tie();
    logic [4:0]  first_aw, second_aw;
    logic [31:0] first_wd, second_wd;
`ifdef REGWRITE_MEM_PRIORITY_EN
    first_aw = 5'd4; first_wd = 32'hB; second_aw = 5'd3; second_wd = 32'hA;
`else
    first_aw = 5'd3; first_wd = 32'hA; second_aw = 5'd4; second_wd = 32'hB;
`endif
    do_reset();
    step(1, 5'd3, 32'hA, 1, 5'd4, 32'hB);
    idle();
    total++;
    if (RegWrite !== 1'b1 || AW !== first_aw || WriteData !== first_wd) begin
      bad++;
      $display("FAIL tie_first: rw=%b aw=%0d wd=%h want 1 %0d %h", RegWrite, AW, WriteData, first_aw, first_wd);
    end
    idle();
    total++;
    if (RegWrite !== 1'b1 || AW !== second_aw || WriteData !== second_wd) begin
      bad++;
      $display("FAIL tie_second: rw=%b aw=%0d wd=%h want 1 %0d %h", RegWrite, AW, WriteData, second_aw, second_wd);
    end
    idle();
    total++;
    if (RegWrite !== 1'b0 || Busy !== 1'b0) begin
      bad++;
      $display("FAIL tie_done: rw=%b busy=%b want 0 0", RegWrite, Busy);
    end
  endtask

  task automatic test_full();
    int acc, n_exp;
    logic [31:0] seen[$];
`ifdef REGWRITE_MEM_PRIORITY_EN
    n_exp = 2;
`else
    n_exp = 3;
`endif
    do_reset();
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, 5'(i + 1), 32'hA0 + 32'(acc), 1, 5'(i + 10), 32'hB0 + 32'(i));
      if (obs_alu_acc) acc++;
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL full_cycle%0d: got %h want %h", i, dut_vec(), model_vec());
      end
      if (RegWrite && WriteData[7:4] == 4'hA) seen.push_back(WriteData);
    end
    for (int i = 0; i < 8; i++) begin
      idle();
      if (RegWrite && WriteData[7:4] == 4'hA) seen.push_back(WriteData);
    end
    total++;
    if (acc != n_exp) begin
      bad++;
      $display("FAIL full_accepts: got %0d want %0d", acc, n_exp);
    end
    total++;
    if (seen.size() != n_exp) begin
      bad++;
      $display("FAIL full_write_count: got %0d want %0d", seen.size(), n_exp);
    end else begin
      for (int i = 0; i < n_exp; i++) begin
        total++;
        if (seen[i] !== 32'hA0 + 32'(i)) begin
          bad++;
          $display("FAIL full_order%0d: got %h want %h", i, seen[i], 32'hA0 + 32'(i));
        end
      end
    end
  endtask

  task automatic test_reg0();
    do_reset();
    step(0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFF);
    total++;
    if (Busy !== 1'b1) begin
      bad++;
      $display("FAIL reg0_busy: got %b want 1", Busy);
    end
    idle();
    total++;
    if (RegWrite !== 1'b0 || WriteData !== 32'hFFFF || AW !== 5'd0 || MemReady !== 1'b1) begin
      bad++;
      $display("FAIL reg0_pop: rw=%b wd=%h aw=%0d rdy=%b want 0 ffff 0 1", RegWrite, WriteData, AW, MemReady);
    end
    idle();
    total++;
    if (RegWrite !== 1'b0 || Busy !== 1'b0) begin
      bad++;
      $display("FAIL reg0_idle: rw=%b busy=%b want 0 0", RegWrite, Busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 5'(i + 1), 32'h100 + 32'(i), 1, 5'(i + 20), 32'h200 + 32'(i));
    total++;
    if (RegWrite !== 1'b1 || Busy !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_before: rw=%b busy=%b want 1 1", RegWrite, Busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({RegWrite, AW, WriteData, Busy} !== 39'd0) begin
      bad++;
      $display("FAIL rstmid_async: got %h want 0", {RegWrite, AW, WriteData, Busy});
    end
    model_reset();
    AluValid = 0; MemValid = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle();
      total++;
      if ({RegWrite, AluReady, MemReady, Busy} !== 4'b0110) begin
        bad++;
        $display("FAIL rstmid_after%0d: rw/rdyA/rdyM/busy got %b want 0110", i,
                 {RegWrite, AluReady, MemReady, Busy});
      end
    end
  endtask

  task automatic test_streaming();
    int writes;
    do_reset();
    writes = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        step(1, 5'(i + 1), 32'hC0 + 32'(i), 0, 5'd0, 32'd0);
        total++;
        if (!obs_alu_acc) begin
          bad++;
          $display("FAIL stream_ready%0d: accepted=0 want 1", i);
        end
      end else begin
        idle();
      end
      if (RegWrite) writes++;
      if (i >= 1 && i <= 8) begin
        total++;
        if (RegWrite !== 1'b1 || WriteData !== 32'hC0 + 32'(i - 1)) begin
          bad++;
          $display("FAIL stream_write%0d: rw=%b wd=%h want 1 %h", i, RegWrite, WriteData, 32'hC0 + 32'(i - 1));
        end
      end
    end
    total++;
    if (writes != 8) begin
      bad++;
      $display("FAIL stream_count: got %0d want 8", writes);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, 5'($urandom_range(0, 31)), $urandom,
           ($urandom % 3) != 0, 5'($urandom_range(0, 31)), $urandom);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    obs_alu_acc = 1'b0;
    model_reset();
    test_reset();
    test_single_write();
    test_tie();
    test_full();
    test_reg0();
    test_reset_mid();
    test_streaming();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
